// File: rtl/fft_job_ctrl_pkg.sv
// Shared definitions for the FFT job controller: register map,
// STATUS field offsets and the per-channel state encoding.
package fft_job_ctrl_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd2;
  localparam logic [2:0] ADDR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ADDR_CH_SEL   = 3'd4;
  localparam logic [2:0] ADDR_LAST_CYC = 3'd5;
  localparam logic [2:0] ADDR_BUSY_IN  = 3'd6;

  localparam int OFF_ACTIVE  = 0;
  localparam int OFF_DONE    = 8;
  localparam int OFF_TIMEOUT = 16;
  localparam int OFF_OVERRUN = 24;

  // Offset of the timeout-enable field inside IRQ_EN.
  localparam int OFF_EN_TO = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/fft_job_chan.sv
// One job channel: start/wait FSM, saturating cycle counter, latched
// job latency and the done / timeout / overrun sticky flags.
module fft_job_chan
  import fft_job_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_req,
  input  logic [2:0]       clr_mask,   // [0] done, [1] timeout, [2] overrun
  input  logic [CNT_W-1:0] timeout,
  input  logic             job_done,
  output logic             job_start,
  output logic             active,
  output logic             done_flag,
  output logic             to_flag,
  output logic             ovr_flag,
  output logic [CNT_W-1:0] last_cyc
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             ovr_q, ovr_d;
  logic             to_hit;
  logic             done_evt;
  logic             to_evt;

  // A zero TIMEOUT expires on the first WAIT cycle even though the count is already 1.
  assign to_hit   = (cnt_q == timeout) || (timeout == '0);
  assign done_evt = (state_q == WAIT) && job_done;
  assign to_evt   = (state_q == WAIT) && !job_done && to_hit;

  // State and datapath registers, synchronously cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic; done takes priority over the timeout compare.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_req) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (job_done || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter, latency latch and stickies; a set beats a same-cycle clear.
  always_comb begin
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE:    if (start_req) cnt_d = '0;
      START:   cnt_d = CNT_W'(1);
      WAIT:    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    last_d = done_evt ? cnt_q : last_q;
    done_d = (done_q & ~clr_mask[0]) | done_evt;
    to_d   = (to_q & ~clr_mask[1]) | to_evt;
    ovr_d  = (ovr_q & ~clr_mask[2]) | (start_req && (state_q != IDLE));
  end

  // Moore outputs decoded from the current state and flags.
  always_comb begin
    job_start = (state_q == START);
    active    = (state_q != IDLE);
    done_flag = done_q;
    to_flag   = to_q;
    ovr_flag  = ovr_q;
    last_cyc  = last_q;
  end

endmodule

// File: rtl/fft_job_ctrl.sv
// Avalon-MM job controller for the reverb FFT wrappers: register
// decode, shared configuration, readback mux and the interrupt.
module fft_job_ctrl
  import fft_job_ctrl_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_RST = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  output logic [31:0]     avs_readdata,
  output logic            irq,
  output logic [N_CH-1:0] job_start,
  input  logic [N_CH-1:0] job_busy,
  input  logic [N_CH-1:0] job_done
);

  logic [N_CH-1:0]  done_en_q, done_en_d;
  logic [N_CH-1:0]  to_en_q, to_en_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [2:0]       ch_sel_q, ch_sel_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_ctrl;
  logic             wr_status;
  logic [N_CH-1:0]  active;
  logic [N_CH-1:0]  done_flag;
  logic [N_CH-1:0]  to_flag;
  logic [N_CH-1:0]  ovr_flag;
  logic [CNT_W-1:0] last_cyc [N_CH];
  logic [CNT_W-1:0] last_sel;
  logic             unused_wdata;

  assign wr_ctrl      = avs_write && (avs_address == ADDR_CTRL);
  assign wr_status    = avs_write && (avs_address == ADDR_STATUS);
  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    fft_job_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .start_req (wr_ctrl && avs_writedata[i]),
      .clr_mask  ({avs_writedata[OFF_OVERRUN+i],
                   avs_writedata[OFF_TIMEOUT+i],
                   avs_writedata[OFF_DONE+i]} & {3{wr_status}}),
      .timeout   (timeout_q),
      .job_done  (job_done[i]),
      .job_start (job_start[i]),
      .active    (active[i]),
      .done_flag (done_flag[i]),
      .to_flag   (to_flag[i]),
      .ovr_flag  (ovr_flag[i]),
      .last_cyc  (last_cyc[i])
    );
  end

  // Configuration and readback registers, synchronously cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_en_q <= '0;
      to_en_q   <= '0;
      timeout_q <= CNT_W'(TIMEOUT_RST);
      ch_sel_q  <= '0;
      rdata_q   <= '0;
    end else begin
      done_en_q <= done_en_d;
      to_en_q   <= to_en_d;
      timeout_q <= timeout_d;
      ch_sel_q  <= ch_sel_d;
      rdata_q   <= rdata_d;
    end
  end

  // Writes to the configuration registers; unimplemented bits are dropped.
  always_comb begin
    done_en_d = done_en_q;
    to_en_d   = to_en_q;
    timeout_d = timeout_q;
    ch_sel_d  = ch_sel_q;
    if (avs_write) begin
      case (avs_address)
        ADDR_IRQ_EN: begin
          done_en_d = avs_writedata[N_CH-1:0];
          to_en_d   = avs_writedata[OFF_EN_TO +: N_CH];
        end
        ADDR_TIMEOUT: timeout_d = avs_writedata[CNT_W-1:0];
        ADDR_CH_SEL:  ch_sel_d  = avs_writedata[2:0];
        default:      ;
      endcase
    end
  end

  // Selects the latency of the channel named by CH_SEL; absent channels read 0.
  always_comb begin
    last_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel_q == 3'(i)) last_sel = last_cyc[i];
    end
  end

  // Read mux, captured on a read strobe and held until the next read.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      case (avs_address)
        ADDR_STATUS: begin
          for (int i = 0; i < N_CH; i++) begin
            rdata_d[OFF_ACTIVE+i]  = active[i];
            rdata_d[OFF_DONE+i]    = done_flag[i];
            rdata_d[OFF_TIMEOUT+i] = to_flag[i];
            rdata_d[OFF_OVERRUN+i] = ovr_flag[i];
          end
        end
        ADDR_IRQ_EN: begin
          rdata_d[N_CH-1:0]          = done_en_q;
          rdata_d[OFF_EN_TO +: N_CH] = to_en_q;
        end
        ADDR_TIMEOUT:  rdata_d[CNT_W-1:0] = timeout_q;
        ADDR_CH_SEL:   rdata_d[2:0]       = ch_sel_q;
        ADDR_LAST_CYC: rdata_d[CNT_W-1:0] = last_sel;
        ADDR_BUSY_IN:  rdata_d[N_CH-1:0]  = job_busy;
        default:       rdata_d = '0;
      endcase
    end
  end

  // Level interrupt from enabled done and timeout stickies.
  always_comb begin
    avs_readdata = rdata_q;
    irq          = |((done_flag & done_en_q) | (to_flag & to_en_q));
  end

endmodule

// File: tb/tb_fft_job_ctrl.sv
// Scoreboard bench for fft_job_ctrl with two channels.
module tb_fft_job_ctrl;

  localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_IRQ_EN = 3'd2, A_TIMEOUT = 3'd3;
  localparam logic [2:0] A_CH_SEL = 3'd4, A_LAST = 3'd5, A_BUSY = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [1:0]  job_start;
  logic [1:0]  job_busy = 2'b10;
  logic [1:0]  job_done = '0;

  int checks = 0;
  int errors = 0;
  int start_cnt [2] = '{0, 0};
  logic [31:0] exp_q [$];

  fft_job_ctrl #(.N_CH(2), .CNT_W(16), .TIMEOUT_RST(50000)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .job_start(job_start), .job_busy(job_busy), .job_done(job_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Counts job_start pulses per channel, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) if (job_start[i]) start_cnt[i]++;
    end
  end

  // Guards against the bench stalling.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic pulse_done(input logic [1:0] m);
    @(negedge clk);
    job_done = m;
    @(negedge clk);
    job_done = '0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp;
    logic [31:0] rst_exp [8];
    rst_exp = '{32'h0, 32'h0, 32'h0, 32'd50000, 32'h0, 32'h0, 32'h2, 32'h0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      exp_q.push_back(rst_exp[a]);
      bus_read(3'(a), rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("[TB] FAIL reset_rd addr%0d got %h exp %h", a, rd, exp); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b exp 0", irq); end
    checks++;
    if (start_cnt[0] + start_cnt[1] != 0) begin
      errors++; $display("[TB] FAIL reset_start got %0d exp 0", start_cnt[0] + start_cnt[1]);
    end
  endtask

  task automatic test_done();
    logic [31:0] rd, exp;
    bus_write(A_CTRL, 32'h1);
    checks++;
    if (job_start !== 2'b01) begin errors++; $display("[TB] FAIL done_start got %b exp 01", job_start); end
    repeat (9) @(negedge clk);
    pulse_done(2'b01);
    exp_q.push_back(32'h100);
    bus_read(A_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL done_status got %h exp %h", rd, exp); end
    bus_write(A_CH_SEL, 32'h0);
    exp_q.push_back(32'd10);
    bus_read(A_LAST, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL done_last got %0d exp %0d", rd, exp); end
    bus_write(A_STATUS, 32'h100);
    exp_q.push_back(32'h0);
    bus_read(A_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL done_w1c got %h exp %h", rd, exp); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd, exp;
    bus_write(A_TIMEOUT, 32'd5);
    bus_write(A_IRQ_EN, 32'h100);
    bus_write(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL to_early_irq got %b exp 0", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL to_irq got %b exp 1", irq); end
    exp_q.push_back(32'h10000);
    bus_read(A_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL to_status got %h exp %h", rd, exp); end
    bus_write(A_STATUS, 32'h10000);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL to_w1c_irq got %b exp 0", irq); end
    bus_write(A_TIMEOUT, 32'd0);
    bus_write(A_CTRL, 32'h2);
    @(negedge clk);
    exp_q.push_back(32'h20000);
    bus_read(A_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL to_zero got %h exp %h", rd, exp); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL to_mask_irq got %b exp 0", irq); end
    bus_write(A_STATUS, 32'hFFFFFF00);
  endtask

  task automatic test_overrun();
    logic [31:0] rd, exp;
    int base;
    base = start_cnt[1];
    bus_write(A_TIMEOUT, 32'd1000);
    bus_write(A_CTRL, 32'h2);
    bus_write(A_CTRL, 32'h2);
    exp_q.push_back(32'h02000002);
    bus_read(A_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL ovr_status got %h exp %h", rd, exp); end
    pulse_done(2'b10);
    exp_q.push_back(32'h02000200);
    bus_read(A_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL ovr_done got %h exp %h", rd, exp); end
    bus_write(A_CH_SEL, 32'h1);
    exp_q.push_back(32'd5);
    bus_read(A_LAST, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL ovr_last got %0d exp %0d", rd, exp); end
    checks++;
    if (start_cnt[1] - base != 1) begin errors++; $display("[TB] FAIL ovr_pulses got %0d exp 1", start_cnt[1] - base); end
    bus_write(A_STATUS, 32'hFFFFFF00);
    exp_q.push_back(32'h0);
    bus_read(A_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL ovr_w1c got %h exp %h", rd, exp); end
  endtask

  task automatic test_done_vs_timeout();
    logic [31:0] rd, exp;
    bus_write(A_TIMEOUT, 32'd8);
    bus_write(A_CTRL, 32'h1);
    repeat (7) @(negedge clk);
    @(negedge clk);
    job_done = 2'b01;
    avs_address = A_STATUS; avs_writedata = 32'h100; avs_write = 1'b1;
    @(negedge clk);
    job_done = '0; avs_write = 1'b0;
    exp_q.push_back(32'h100);
    bus_read(A_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL dvt_status got %h exp %h", rd, exp); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL dvt_irq got %b exp 0", irq); end
    bus_write(A_CH_SEL, 32'h0);
    exp_q.push_back(32'd8);
    bus_read(A_LAST, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL dvt_last got %0d exp %0d", rd, exp); end
    bus_write(A_STATUS, 32'hFFFFFF00);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp;
    int b0, b1;
    logic [31:0] post_exp [4];
    logic [2:0]  post_addr [4];
    bus_write(A_TIMEOUT, 32'd1000);
    bus_write(A_IRQ_EN, 32'h3);
    b0 = start_cnt[0]; b1 = start_cnt[1];
    bus_write(A_CTRL, 32'h3);
    repeat (3) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL b2b_irq_pre got %b exp 0", irq); end
    pulse_done(2'b10);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL b2b_irq got %b exp 1", irq); end
    repeat (2) @(negedge clk);
    pulse_done(2'b01);
    exp_q.push_back(32'h300);
    bus_read(A_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL b2b_status got %h exp %h", rd, exp); end
    for (int c = 0; c < 2; c++) begin
      bus_write(A_CH_SEL, 32'(c));
      exp_q.push_back((c == 0) ? 32'd8 : 32'd4);
      bus_read(A_LAST, rd);
      exp = exp_q.pop_front(); checks++;
      if (rd !== exp) begin errors++; $display("[TB] FAIL b2b_last ch%0d got %0d exp %0d", c, rd, exp); end
    end
    checks++;
    if (start_cnt[0] - b0 != 1 || start_cnt[1] - b1 != 1) begin
      errors++; $display("[TB] FAIL b2b_pulses got %0d/%0d exp 1/1", start_cnt[0] - b0, start_cnt[1] - b1);
    end
    b0 = start_cnt[0]; b1 = start_cnt[1];
    bus_write(A_CTRL, 32'h3);
    repeat (3) @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt[0] - b0 != 1 || start_cnt[1] - b1 != 1) begin
      errors++; $display("[TB] FAIL rst_pulses got %0d/%0d exp 1/1", start_cnt[0] - b0, start_cnt[1] - b1);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq got %b exp 0", irq); end
    post_addr = '{A_STATUS, A_TIMEOUT, A_IRQ_EN, A_LAST};
    post_exp  = '{32'h0, 32'd50000, 32'h0, 32'h0};
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(post_exp[k]);
      bus_read(post_addr[k], rd);
      exp = exp_q.pop_front(); checks++;
      if (rd !== exp) begin errors++; $display("[TB] FAIL rst_rd addr%0d got %h exp %h", post_addr[k], rd, exp); end
    end
  endtask

  // Runs the scenarios in order and prints the summary.
  initial begin
    test_reset();
    test_done();
    test_timeout();
    test_overrun();
    test_done_vs_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
